uart_transceiver: RTL and testbench
===================================

Name: uart_transceiver

Overview:
Full-duplex 8N1 UART for the ICE host link: one serial transmitter and one serial receiver sharing one clock and a runtime baud divisor. The host side pushes bytes with a single-cycle latch strobe and watches `tx_empty`. The receiver reports each good byte with a single-cycle `rx_latch` pulse. It sits between the USB-UART pins and the ICE command/response logic.

Parameters:
DATA_BITS, 8, data bits per frame (LSB first, no parity, 1 stop bit).
SYNC_STAGES, 2, flip-flop stages on the `rx_in` synchronizer.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset.
baud_div  input  16  clock cycles per bit (40 MHz with 174 gives about 230 kbaud).
rx_in  input  1  serial receive line, idles high.
rx_latch  output  1  one-cycle pulse: `rx_data` holds a new byte.
rx_data  output  8  last good received byte.
tx_out  output  1  serial transmit line, idles high.
tx_latch  input  1  strobe: load `tx_data` and start a frame.
tx_data  input  8  byte to transmit, sampled only in the `tx_latch` cycle.
tx_empty  output  1  high when the transmitter is idle and can accept a byte.

Behaviour:
- Reset (`reset` = 0, asynchronous):
  - `tx_out` = 1, `tx_empty` = 1, `rx_latch` = 0, `rx_data` = 0x00.
  - Both state machines go to IDLE and all counters clear.
  - A frame in progress is abandoned with no partial output.
- Baud divisor:
  - `baud_div` is captured at the start of each TX frame and each RX frame; changes mid-frame have no effect.
  - Effective divisor = max(`baud_div`, 4).
- TX state machine: IDLE -> START -> DATA(8) -> STOP -> IDLE.
  - IDLE: on `tx_latch` = 1, capture `tx_data`; on the next edge `tx_empty` = 0, `tx_out` = 0 and START begins.
  - Each bit is driven for exactly `div` cycles: start bit 0, then d[0]..d[7], then stop bit 1.
  - `tx_empty` returns to 1 on the cycle after the stop bit completes. `tx_empty` is therefore low for 10×`div` cycles per byte.
  - `tx_latch` while busy (`tx_empty` = 0) is ignored; the byte is lost and the current frame is not disturbed.
  - `tx_latch` in the same cycle `tx_empty` rises is accepted.
- RX input: `rx_in` passes through a SYNC_STAGES flip-flop synchronizer; all RX logic uses the synchronized value.
- RX state machine: IDLE -> START -> DATA(8) -> STOP -> IDLE, plus WAIT_HIGH.
  - IDLE: a synchronized 1->0 transition enters START.
  - START: wait `div`/2 (integer floor) cycles and re-sample. If the line is 1, treat it as a glitch and return to IDLE; if 0, go to DATA.
  - DATA: sample every `div` cycles (mid-bit), shifting LSB first, 8 samples.
  - STOP: sample after `div` more cycles.
    - Sample = 1: load `rx_data` and pulse `rx_latch` for exactly 1 cycle (the cycle after the sample); go to IDLE.
    - Sample = 0 (framing error): no pulse and `rx_data` unchanged; go to WAIT_HIGH.
  - WAIT_HIGH: stay until the synchronized line reads 1, then go to IDLE.
  - Receive latency: `rx_latch` fires about 9.5×`div` + SYNC_STAGES + 1 cycles after the start-bit falling edge.
- `rx_data` holds its value until the next good byte.
- TX and RX are fully independent; simultaneous activity is required to work (loopback).

Decomposition:
- Shared package `uart_pkg`: FRAME_BITS = 10, IDLE_LEVEL = 1'b1, MIN_DIV = 4, and the TX/RX state enums.
- One natural sub-module, `uart_rx_sync`: the SYNC_STAGES input synchronizer plus falling-edge detect.
- TX and RX FSMs stay in the top module.

Test Plan:
- Reset values: hold `reset` = 0 mid-operation -> `tx_out` = 1, `tx_empty` = 1, `rx_latch` = 0, `rx_data` = 0x00. After release, a new `tx_latch` of 0x3C transmits a clean frame.
- TX 0x55 with `baud_div` = 174:
  - `tx_out` bit sequence 0,1,0,1,0,1,0,1,0,1, each bit 174 cycles.
  - `tx_empty` low for exactly 1740 cycles.
- Loopback (`tx_out` -> `rx_in`), `baud_div` = 174, bytes 0xA5, 0x00, 0xFF sent back-to-back as `tx_empty` rises -> three single-cycle `rx_latch` pulses with `rx_data` = 0xA5, 0x00, 0xFF.
- Busy TX: `tx_latch` with 0x12, then `tx_latch` with 0x34 500 cycles later -> only 0x12 appears on `tx_out`, and `tx_empty` timing is unchanged.
- RX glitch: `rx_in` low for 50 cycles with `baud_div` = 174 -> no `rx_latch`; a following valid 0x81 frame is received correctly.
- Framing error: frame 0x7E with stop bit 0, then line held low 400 cycles and released -> no `rx_latch`, `rx_data` unchanged. A following valid 0xC3 frame gives `rx_latch` with `rx_data` = 0xC3.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants, FSM state types and the baud-divisor clamp used by the
// 8N1 UART transceiver and its receive-line synchronizer.
// ---------------------------------------------------------------------------
package uart_pkg;

    // start + 8 data + stop
    localparam int unsigned FRAME_BITS = 10;
    localparam logic        IDLE_LEVEL = 1'b1;
    localparam int unsigned MIN_DIV    = 4;
    localparam int unsigned DIV_W      = 16;

    typedef enum logic [1:0] {
        TxIdle,
        TxStart,
        TxData,
        TxStop
    } tx_state_e;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop,
        RxWaitHigh
    } rx_state_e;

    // Very small divisors would leave no room for a mid-bit sample point.
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] div);
        return (div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Multi-stage synchronizer for the asynchronous serial receive line, plus a
// falling-edge detector on the synchronized value (start-bit detection).
//
// Ports:
//   i_clk    system clock
//   i_reset  asynchronous active-low reset (line assumed idle/high)
//   i_rx     raw serial input
//   o_rx     synchronized serial level
//   o_fall   one-cycle strobe: synchronized line just went 1 -> 0
// ---------------------------------------------------------------------------
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_rx,
    output logic o_rx,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_sync <= {SYNC_STAGES{IDLE_LEVEL}};
            r_prev <= IDLE_LEVEL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rx   = r_sync[SYNC_STAGES-1];
    assign o_fall = r_prev & ~o_rx;

endmodule

// File: rtl/uart_transceiver.sv
// ---------------------------------------------------------------------------
// uart_transceiver
// Full-duplex 8N1 UART for the ICE host link. Independent TX and RX state
// machines share one clock and a runtime baud divisor; each direction
// captures the (clamped) divisor at the start of its frame.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   baud_div  clock cycles per bit (clamped to >= MIN_DIV)
//   rx_in     serial receive line, idles high
//   rx_latch  one-cycle pulse: rx_data holds a new good byte
//   rx_data   last good received byte
//   tx_out    serial transmit line, idles high
//   tx_latch  strobe: load tx_data and start a frame (ignored while busy)
//   tx_data   byte to transmit, sampled only with tx_latch
//   tx_empty  transmitter idle and able to accept a byte
// ---------------------------------------------------------------------------
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 rx_in,
    output logic                 rx_latch,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 tx_out,
    input  logic                 tx_latch,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_empty
);

    localparam int unsigned         BitCntW     = $clog2(FRAME_BITS);
    localparam logic [BitCntW-1:0]  LastDataBit = BitCntW'(DATA_BITS - 1);

    // -----------------------------------------------------------------------
    // Transmitter
    // -----------------------------------------------------------------------
    tx_state_e              r_tx_state;
    logic [DIV_W-1:0]       r_tx_div;
    logic [DIV_W-1:0]       r_tx_cnt;
    logic [BitCntW-1:0]     r_tx_bit;
    logic [DATA_BITS-1:0]   r_tx_shift;
    logic                   r_tx_out;
    logic                   r_tx_empty;
    logic                   w_tx_bit_end;

    assign w_tx_bit_end = (r_tx_cnt == r_tx_div - DIV_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= TxIdle;
            r_tx_div   <= DIV_W'(MIN_DIV);
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_out   <= IDLE_LEVEL;
            r_tx_empty <= 1'b1;
        end else begin
            unique case (r_tx_state)
                TxIdle: begin
                    if (tx_latch) begin
                        r_tx_shift <= tx_data;
                        r_tx_div   <= eff_div(baud_div);
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx_out   <= 1'b0;
                        r_tx_empty <= 1'b0;
                        r_tx_state <= TxStart;
                    end
                end
                TxStart: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt   <= '0;
                        r_tx_out   <= r_tx_shift[0];
                        r_tx_state <= TxData;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + DIV_W'(1);
                    end
                end
                TxData: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == LastDataBit) begin
                            r_tx_out   <= IDLE_LEVEL;
                            r_tx_state <= TxStop;
                        end else begin
                            // Drive the next bit directly; the shift catches up.
                            r_tx_out   <= r_tx_shift[1];
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_bit   <= r_tx_bit + BitCntW'(1);
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + DIV_W'(1);
                    end
                end
                TxStop: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt   <= '0;
                        r_tx_empty <= 1'b1;
                        r_tx_state <= TxIdle;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + DIV_W'(1);
                    end
                end
                default: r_tx_state <= TxIdle;
            endcase
        end
    end

    assign tx_out   = r_tx_out;
    assign tx_empty = r_tx_empty;

    // -----------------------------------------------------------------------
    // Receiver
    // -----------------------------------------------------------------------
    logic w_rx_sync;
    logic w_rx_fall;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_rx    (rx_in),
        .o_rx    (w_rx_sync),
        .o_fall  (w_rx_fall)
    );

    rx_state_e              r_rx_state;
    logic [DIV_W-1:0]       r_rx_div;
    logic [DIV_W-1:0]       r_rx_cnt;
    logic [BitCntW-1:0]     r_rx_bit;
    logic [DATA_BITS-1:0]   r_rx_shift;
    logic [DATA_BITS-1:0]   r_rx_data;
    logic                   r_rx_latch;
    logic                   w_rx_bit_end;
    logic                   w_rx_half_end;

    assign w_rx_bit_end  = (r_rx_cnt == r_rx_div - DIV_W'(1));
    assign w_rx_half_end = (r_rx_cnt == (r_rx_div >> 1) - DIV_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state <= RxIdle;
            r_rx_div   <= DIV_W'(MIN_DIV);
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_latch <= 1'b0;
        end else begin
            r_rx_latch <= 1'b0;
            unique case (r_rx_state)
                RxIdle: begin
                    if (w_rx_fall) begin
                        r_rx_div   <= eff_div(baud_div);
                        r_rx_cnt   <= '0;
                        r_rx_state <= RxStart;
                    end
                end
                RxStart: begin
                    // Re-check the start bit half a bit later; from here on every
                    // sample lands mid-bit.
                    if (w_rx_half_end) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        if (w_rx_sync) begin
                            r_rx_state <= RxIdle;
                        end else begin
                            r_rx_state <= RxData;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + DIV_W'(1);
                    end
                end
                RxData: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {w_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit == LastDataBit) begin
                            r_rx_state <= RxStop;
                        end else begin
                            r_rx_bit <= r_rx_bit + BitCntW'(1);
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + DIV_W'(1);
                    end
                end
                RxStop: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt <= '0;
                        if (w_rx_sync) begin
                            r_rx_data  <= r_rx_shift;
                            r_rx_latch <= 1'b1;
                            r_rx_state <= RxIdle;
                        end else begin
                            // Framing error: drop the byte, wait out the low line.
                            r_rx_state <= RxWaitHigh;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + DIV_W'(1);
                    end
                end
                RxWaitHigh: begin
                    if (w_rx_sync) begin
                        r_rx_state <= RxIdle;
                    end
                end
                default: r_rx_state <= RxIdle;
            endcase
        end
    end

    assign rx_latch = r_rx_latch;
    assign rx_data  = r_rx_data;

endmodule

// File: tb/tb_uart_transceiver.sv
// ---------------------------------------------------------------------------
// tb_uart_transceiver
// Scoreboard bench: stimulus pushes expected TX frames, tx_empty low times and
// received bytes into queues; independent monitors on tx_out, tx_empty and
// rx_latch pop and compare. Expected frames come from the 8N1 frame rule.
// ---------------------------------------------------------------------------
module tb_uart_transceiver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] baud_div = 16'd174;
    logic        rx_drv = 1'b1;
    logic        loop_en = 1'b1;
    logic        rx_in;
    logic        rx_latch;
    logic [7:0]  rx_data;
    logic        tx_out;
    logic        tx_latch = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_empty;

    assign rx_in = loop_en ? tx_out : rx_drv;

    always #5 clk = ~clk;

    uart_transceiver #(
        .DATA_BITS   (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .baud_div (baud_div),
        .rx_in    (rx_in),
        .rx_latch (rx_latch),
        .rx_data  (rx_data),
        .tx_out   (tx_out),
        .tx_latch (tx_latch),
        .tx_data  (tx_data),
        .tx_empty (tx_empty)
    );

    typedef struct {
        logic [7:0]  data;
        int unsigned div;
    } tx_exp_t;

    tx_exp_t     tx_q[$];
    int unsigned te_q[$];
    logic [7:0]  rx_q[$];
    int          checks = 0;
    int          passes = 0;
    logic [7:0]  last_good = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic flag_fail(input string msg);
        checks++;
        $display("FAIL %s", msg);
    endtask

    // Reference model: clamped divisor and the 8N1 frame bit rule.
    function automatic int unsigned model_div(input int unsigned d);
        return (d < 4) ? 4 : d;
    endfunction

    function automatic logic frame_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return d[i-1];
    endfunction

    // ---------------- TX line monitor ----------------
    bit          txm_active = 0;
    bit          txm_lost = 0;
    int unsigned txm_bit, txm_cyc, txm_bad;
    tx_exp_t     txm_cur;

    always @(negedge clk) begin
        if (!reset) begin
            txm_active = 0;
            txm_lost   = 0;
        end else begin
            if (txm_lost && tx_out === 1'b1) txm_lost = 0;
            if (!txm_active && !txm_lost && tx_out !== 1'b1) begin
                if (tx_q.size() == 0) begin
                    flag_fail($sformatf("tx_unexpected_start: tx_out=%b with no frame queued, required 1",
                                        tx_out));
                    txm_lost = 1;
                end else begin
                    txm_cur    = tx_q.pop_front();
                    txm_active = 1;
                    txm_bit    = 0;
                    txm_cyc    = 0;
                    txm_bad    = 0;
                end
            end
            if (txm_active) begin
                if (tx_out !== frame_bit(txm_cur.data, int'(txm_bit))) txm_bad++;
                txm_cyc++;
                if (txm_cyc == txm_cur.div) begin
                    chk($sformatf("tx_bit%0d_byte%02h_wrong_cycles", txm_bit, txm_cur.data),
                        32'(txm_bad), 32'd0);
                    txm_bit++;
                    txm_cyc = 0;
                    txm_bad = 0;
                    if (txm_bit == 10) txm_active = 0;
                end
            end
        end
    end

    // ---------------- tx_empty low-time monitor ----------------
    int unsigned te_low = 0;

    always @(negedge clk) begin
        if (!reset) begin
            te_low = 0;
        end else if (tx_empty !== 1'b1) begin
            te_low++;
        end else if (te_low > 0) begin
            if (te_q.size() == 0)
                flag_fail($sformatf("tx_empty_unexpected: low %0d cycles, required no busy period",
                                    te_low));
            else
                chk("tx_empty_low_cycles", 32'(te_low), 32'(te_q.pop_front()));
            te_low = 0;
        end
    end

    // ---------------- RX monitor ----------------
    logic prev_latch = 1'b0;

    always @(negedge clk) begin : rx_mon
        logic [7:0] e;
        if (!reset) begin
            prev_latch = 1'b0;
        end else begin
            if (rx_latch === 1'b1) begin
                chk("rx_latch_prev_cycle", 32'(prev_latch), 32'd0);
                if (rx_q.size() == 0) begin
                    flag_fail($sformatf("rx_unexpected_latch: rx_data=0x%02h, required no pulse",
                                        rx_data));
                end else begin
                    e = rx_q.pop_front();
                    chk("rx_data", 32'(rx_data), 32'(e));
                    last_good = e;
                end
            end
            prev_latch = rx_latch;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_send(input logic [7:0] b, input logic [15:0] div);
        int      n = 0;
        tx_exp_t e;
        while (tx_empty !== 1'b1 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30000) flag_fail($sformatf("tx_send_timeout: tx_empty=%b, required 1", tx_empty));
        baud_div = div;
        tx_data  = b;
        tx_latch = 1'b1;
        e.data   = b;
        e.div    = model_div(32'(div));
        tx_q.push_back(e);
        te_q.push_back(10 * e.div);
        if (loop_en) rx_q.push_back(b);
        @(negedge clk);
        tx_latch = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic rx_drive_frame(input logic [7:0] b, input logic stop, input logic [15:0] div);
        baud_div = div;
        if (stop) rx_q.push_back(b);
        for (int i = 0; i < 10; i++) begin
            rx_drv = (i == 9) ? stop : frame_bit(b, i);
            tick(int'(div));
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((tx_q.size() + te_q.size() + rx_q.size() != 0 || tx_empty !== 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget)
            flag_fail($sformatf("wait_idle_timeout: %0d tx / %0d rx items pending, required 0",
                                tx_q.size(), rx_q.size()));
        tick(4);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tx_out"},   32'(tx_out),   32'd1);
        chk({tag, "_tx_empty"}, 32'(tx_empty), 32'd1);
        chk({tag, "_rx_latch"}, 32'(rx_latch), 32'd0);
        chk({tag, "_rx_data"},  32'(rx_data),  32'h00);
    endtask

    logic [7:0] lb_bytes[3];

    initial begin
        lb_bytes = '{8'hA5, 8'h00, 8'hFF};

        // Reset values at power-up.
        tick(3);
        check_reset_values("por");
        reset = 1'b1;
        tick(3);

        // TX 0x55 at 174 cycles per bit (loopback also receives it).
        tx_send(8'h55, 16'd174);
        wait_idle(4000);

        // Back-to-back loopback, each latched in the cycle tx_empty rises.
        for (int i = 0; i < 3; i++) tx_send(lb_bytes[i], 16'd174);
        wait_idle(8000);

        // Second latch while busy is dropped.
        tx_send(8'h12, 16'd174);
        tick(499);
        tx_data  = 8'h34;
        tx_latch = 1'b1;
        tick(1);
        tx_latch = 1'b0;
        wait_idle(4000);

        // Random bytes and divisors (0..3 exercise the clamp); baud_div is
        // scrambled mid-frame, which must not matter.
        for (int k = 0; k < 12; k++) begin
            tx_send(8'($urandom), 16'($urandom_range(24, 0)));
            tick(8);
            baud_div = 16'($urandom);
        end
        wait_idle(3000);

        // Receiver driven directly: short glitch, then a good frame.
        loop_en = 1'b0;
        tick(20);
        baud_div = 16'd174;
        rx_drv   = 1'b0;
        tick(50);
        rx_drv = 1'b1;
        tick(2000);
        rx_drive_frame(8'h81, 1'b1, 16'd174);
        tick(200);
        wait_idle(2000);

        // Framing error: stop bit low, line held low, then a good frame.
        rx_drive_frame(8'h7E, 1'b0, 16'd174);
        tick(400);
        rx_drv = 1'b1;
        tick(2000);
        chk("rx_data_hold_after_framing_error", 32'(rx_data), 32'(last_good));
        rx_drive_frame(8'hC3, 1'b1, 16'd174);
        tick(200);
        wait_idle(2000);

        // Reset in the middle of a loopback frame.
        loop_en = 1'b1;
        tick(5);
        tx_send(8'h96, 16'd174);
        tick(700);
        #3;
        reset = 1'b0;
        #1;
        check_reset_values("midreset");
        tx_q.delete();
        te_q.delete();
        rx_q.delete();
        last_good = 8'h00;
        tick(3);
        reset = 1'b1;
        tick(3);
        tx_send(8'h3C, 16'd174);
        wait_idle(4000);

        chk("rx_queue_drained", 32'(rx_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule
